// File: rtl/pc_sequencer_if.sv
// Bundle of the fetch, register-read, execute, link and exception signals of the PC sequencer.
// master = the sequencer itself; slave = memory/regfile/datapath side.
// stall travels with the bundle because the datapath owns it.
interface pc_sequencer_if;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        exec_start;
  logic        exec_done;
  logic        link_we;
  logic [31:0] link_data;
  logic        exc_pulse;
  logic [31:0] epc;

  modport master (
    input  stall, imem_ack, imem_rdata, rs_value, rt_value, exec_done,
    output imem_req, imem_addr, ir, pc, exec_start, link_we, link_data, exc_pulse, epc
  );

  modport slave (
    output stall, imem_ack, imem_rdata, rs_value, rt_value, exec_done,
    input  imem_req, imem_addr, ir, pc, exec_start, link_we, link_data, exc_pulse, epc
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle PC/IR controller: fetches via req/ack, resolves J/JAL/JR/BEQ/BNE locally, hands the rest to the datapath.
// Latency: fetch >= 2 cycles (req is raised one cycle after entering FETCH), jumps 1 cycle, branches 2, exec 2 + datapath.
// Backpressure: imem_req held until imem_ack; exec waits on exec_done; stall freezes everything and drops new pulses.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;

  typedef enum logic [2:0] {FETCH, DECODE, BRANCH, EXEC, UPDATE} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] ir_q, ir_nxt;
  logic [31:0] epc_q, epc_nxt;
  logic [31:0] link_data_q, link_data_nxt;
  logic        req_q, req_nxt;
  logic        exec_start_q, exec_start_nxt;
  logic        link_we_q, link_we_nxt;
  logic        exc_q, exc_nxt;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] br_offset;
  logic        br_taken;

  assign opcode      = ir_q[31:26];
  assign funct       = ir_q[5:0];
  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};
  // Word offset, sign-extended to 32 bits before the add.
  assign br_offset   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign br_taken    = (bus.rs_value == bus.rt_value) ^ (opcode == OP_BNE);

  // State and architectural registers; pulses are registered so each lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      pc_q         <= RESET_VECTOR;
      ir_q         <= '0;
      epc_q        <= '0;
      link_data_q  <= '0;
      req_q        <= 1'b0;
      exec_start_q <= 1'b0;
      link_we_q    <= 1'b0;
      exc_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc_q         <= pc_nxt;
      ir_q         <= ir_nxt;
      epc_q        <= epc_nxt;
      link_data_q  <= link_data_nxt;
      req_q        <= req_nxt;
      exec_start_q <= exec_start_nxt;
      link_we_q    <= link_we_nxt;
      exc_q        <= exc_nxt;
    end
  end

  // Next-state logic; under stall everything holds and no pulse is generated.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc_q;
    ir_nxt         = ir_q;
    epc_nxt        = epc_q;
    link_data_nxt  = link_data_q;
    req_nxt        = req_q;
    exec_start_nxt = 1'b0;
    link_we_nxt    = 1'b0;
    exc_nxt        = 1'b0;
    if (!bus.stall) begin
      unique case (state)
        FETCH: begin
          if (req_q) begin
            // An ack only counts while our request is up, so stray acks are ignored.
            if (bus.imem_ack) begin
              ir_nxt    = bus.imem_rdata;
              req_nxt   = 1'b0;
              state_nxt = DECODE;
            end
          end else if (pc_q[1:0] != 2'b00) begin
            epc_nxt = pc_q;
            pc_nxt  = EXC_VECTOR;
            exc_nxt = 1'b1;
          end else begin
            req_nxt = 1'b1;
          end
        end
        DECODE: begin
          if (opcode == OP_J) begin
            pc_nxt    = jump_target;
            state_nxt = FETCH;
          end else if (opcode == OP_JAL) begin
            pc_nxt        = jump_target;
            link_we_nxt   = 1'b1;
            link_data_nxt = pc_plus4;
            state_nxt     = FETCH;
          end else if (opcode == OP_SPECIAL && funct == FN_JR) begin
            pc_nxt    = bus.rs_value;
            state_nxt = FETCH;
          end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
            state_nxt = BRANCH;
          end else begin
            exec_start_nxt = 1'b1;
            state_nxt      = EXEC;
          end
        end
        BRANCH: begin
          pc_nxt    = br_taken ? (pc_plus4 + br_offset) : pc_plus4;
          state_nxt = FETCH;
        end
        EXEC: begin
          if (bus.exec_done) state_nxt = UPDATE;
        end
        UPDATE: begin
          pc_nxt    = pc_plus4;
          state_nxt = FETCH;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.ir         = ir_q;
  assign bus.epc        = epc_q;
  assign bus.exec_start = exec_start_q;
  assign bus.link_we    = link_we_q;
  assign bus.link_data  = link_data_q;
  assign bus.exc_pulse  = exc_q;

endmodule
